// File: rtl/config_loader_pkg.sv
//------------------------------------------------------------------------------
// Module      : config_loader_pkg
// Description : Shared types and sizes for the tile configuration stream loader.
//               Record length depends on CONFIG_STREAM_LOADER_CHECKSUM_EN
//               (9 bytes with trailing XOR checksum, otherwise 8 bytes).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package config_loader_pkg;

  // Loader control states
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    DONE    = 2'd2
  } loader_state_e;

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  localparam int REC_BYTES = 9;
`else
  localparam int REC_BYTES = 8;
`endif

  localparam int CFG_ID_W  = 16;
  localparam int TILE_ID_W = 16;

  // Byte counter width: holds 0..REC_BYTES-1
  localparam int CNT_W     = 4;

endpackage

`default_nettype wire

// File: rtl/config_record_assembler.sv
//------------------------------------------------------------------------------
// Module      : config_record_assembler
// Description : Collects stream bytes into one configuration record. Bytes 0-3
//               form the address, bytes 4-7 the data, both little-endian.
//               With CONFIG_STREAM_LOADER_CHECKSUM_EN a ninth byte carries the
//               XOR of bytes 0-7 and o_rec_ok reports whether it matched.
//               o_rec_valid is combinational: it is high in the cycle the last
//               byte is accepted so the parent can act on the following edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module config_record_assembler
  import config_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_byte,
  input  logic        i_accept,
  output logic        o_rec_valid,
  output logic [31:0] o_rec_addr,
  output logic [31:0] o_rec_data,
  output logic        o_rec_ok,
  output logic        o_partial
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(REC_BYTES - 1);

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  // All eight payload bytes are stored; the checksum byte is only compared
  localparam int SHIFT_W = 64;
`else
  // Byte 7 is taken straight from the input when the record completes
  localparam int SHIFT_W = 56;
`endif

  logic [CNT_W-1:0]   r_count;
  logic [SHIFT_W-1:0] r_shift;
  logic               w_last;
  logic               w_shift;

  assign w_last      = i_accept && (r_count == LAST_IDX);
  assign w_shift     = i_accept && !w_last;
  assign o_rec_valid = w_last;
  assign o_partial   = (r_count != '0);

  // Position of the next byte within the record; wraps after the last byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_accept) begin
      r_count <= w_last ? '0 : (r_count + 1'b1);
    end
  end

  // Bytes enter at the top so byte 0 ends up in the least significant lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_shift) begin
      r_shift <= {i_byte, r_shift[SHIFT_W-1:8]};
    end
  end

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  // Running XOR of payload bytes, seeded fresh by byte 0 of each record
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xor <= '0;
    end else if (w_shift) begin
      r_xor <= (r_count == '0) ? i_byte : (r_xor ^ i_byte);
    end
  end

  assign o_rec_addr = r_shift[31:0];
  assign o_rec_data = r_shift[63:32];
  assign o_rec_ok   = (r_xor == i_byte);
`else
  assign o_rec_addr = r_shift[31:0];
  assign o_rec_data = {i_byte, r_shift[55:32]};
  assign o_rec_ok   = 1'b1;
`endif

endmodule

`default_nettype wire

// File: rtl/config_stream_loader.sv
//------------------------------------------------------------------------------
// Module      : config_stream_loader
// Description : Initiator of the tile configuration bus. Assembles host stream
//               bytes into {addr, data} records and holds each on the bus for
//               HOLD_CYCLES cycles. A record addressed to IDLE_ADDR terminates
//               the load and raises the sticky done flag.
//               Optional feature macro: CONFIG_STREAM_LOADER_CHECKSUM_EN adds a
//               per-record XOR checksum byte and the sticky error flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module config_stream_loader
  import config_loader_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_loaded,
  output logic        error
);

  // Hold counter is loaded with HOLD_CYCLES-1 and counts down to zero
  localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

  loader_state_e r_state;
  logic [3:0]    r_hold;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic          r_write;
  logic          r_done;
  logic [15:0]   r_words;

  logic          w_accept;
  logic          w_rec_valid;
  logic [31:0]   w_rec_addr;
  logic [31:0]   w_rec_data;
  logic          w_rec_ok;
  logic          w_partial;

  // The stream stalls only while a record occupies the bus
  assign in_ready = (r_state != ISSUE);
  assign w_accept = in_valid && in_ready;

  config_record_assembler u_assembler (
    .clk         (clk),
    .rst         (reset),
    .i_byte      (in_data),
    .i_accept    (w_accept),
    .o_rec_valid (w_rec_valid),
    .o_rec_addr  (w_rec_addr),
    .o_rec_data  (w_rec_data),
    .o_rec_ok    (w_rec_ok),
    .o_partial   (w_partial)
  );

  // Control FSM: launches records onto the bus, times the hold, tracks done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= COLLECT;
      r_hold  <= '0;
      r_addr  <= IDLE_ADDR;
      r_data  <= '0;
      r_write <= 1'b0;
      r_done  <= 1'b0;
      r_words <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_rec_valid && w_rec_ok) begin
            if (w_rec_addr == IDLE_ADDR) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ISSUE;
              r_addr  <= w_rec_addr;
              r_data  <= w_rec_data;
              r_write <= 1'b1;
              r_hold  <= HOLD_M1;
            end
          end
        end
        ISSUE: begin
          if (r_hold == '0) begin
            r_state <= COLLECT;
            r_addr  <= IDLE_ADDR;
            r_data  <= '0;
            r_write <= 1'b0;
            if (r_words != 16'hFFFF) begin
              r_words <= r_words + 16'd1;
            end
          end else begin
            r_hold <= r_hold - 4'd1;
          end
        end
        DONE: begin
          // The assembler stores this byte as byte 0 of the next record
          if (w_accept) begin
            r_state <= COLLECT;
            r_done  <= 1'b0;
            r_words <= '0;
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  logic r_error;

  // Sticky checksum failure; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_rec_valid && !w_rec_ok) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign config_addr  = r_addr;
  assign config_data  = r_data;
  assign config_write = r_write;
  assign done         = r_done;
  assign words_loaded = r_words;
  assign busy         = w_partial || (r_state == ISSUE);

endmodule

`default_nettype wire

// File: tb/tb_config_stream_loader.sv
`default_nettype none

module tb_config_stream_loader;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
  localparam int          HOLD = 2;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  localparam int          REC_N = 9;
`else
  localparam int          REC_N = 8;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_write;
  logic        busy;
  logic        done;
  logic [15:0] words_loaded;
  logic        error;

  config_stream_loader #(
    .IDLE_ADDR   (IDLE),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .config_write (config_write),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded),
    .error        (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed bus writes (one entry per contiguous config_write run)
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
    int          start;
  } wr_t;
  wr_t obs_q[$];

  // Reference model: expected writes in order
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int  idle_err = 0;
  int  unstable_err = 0;
  bit  send_timeout = 1'b0;
  int  last_edge = 0;
  int  first_edge = 0;

  logic mon_prev = 1'b0;
  wr_t  mon_cur;

  // Bus monitor sampled on the falling edge
  always @(negedge clk) begin
    if (config_write) begin
      if (!mon_prev) begin
        mon_cur.addr  = config_addr;
        mon_cur.data  = config_data;
        mon_cur.len   = 1;
        mon_cur.start = cyc;
      end else begin
        mon_cur.len = mon_cur.len + 1;
        if (config_addr !== mon_cur.addr || config_data !== mon_cur.data) unstable_err++;
      end
    end else begin
      if (mon_prev) obs_q.push_back(mon_cur);
      if (config_addr !== IDLE || config_data !== 32'h0) idle_err++;
    end
    mon_prev = config_write;
  end

  // Byte i of a record as the host would send it (i == 8 is the XOR checksum)
  function automatic logic [7:0] rec_byte(logic [31:0] a, logic [31:0] d, int i, bit corrupt);
    logic [63:0] r;
    logic [7:0]  x;
    r = {d, a};
    if (i < 8) return r[8*i +: 8];
    x = 8'h00;
    for (int k = 0; k < 8; k++) x = x ^ r[8*k +: 8];
    return corrupt ? ~x : x;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [15:0] tile;
    logic [15:0] cid;
    tile = 16'($urandom_range(0, 16'hFFFE));
    cid  = 16'($urandom);
    return {tile, cid};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int t;
    in_data  = b;
    in_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 64) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) send_timeout = 1'b1;
    last_edge = cyc;
    in_valid  = 1'b0;
    in_data   = 8'($urandom);
  endtask

  task automatic send_record(input logic [31:0] a, input logic [31:0] d, input bit gappy, input bit corrupt);
    for (int i = 0; i < REC_N; i++) begin
      send_byte(rec_byte(a, d, i, corrupt));
      if (i == 0) first_edge = last_edge;
      if (gappy && i != REC_N - 1) wait_cycles(1);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    n_tests++; if (config_addr !== IDLE)  begin n_fail++; $display("FAIL reset_addr got=%h want=%h", config_addr, IDLE); end
    n_tests++; if (config_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h want=0", config_data); end
    n_tests++; if (config_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%0b want=0", config_write); end
    n_tests++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
    n_tests++; if (done !== 1'b0)         begin n_fail++; $display("FAIL reset_done got=%0b want=0", done); end
    n_tests++; if (words_loaded !== 16'h0) begin n_fail++; $display("FAIL reset_words got=%0d want=0", words_loaded); end
    n_tests++; if (error !== 1'b0)        begin n_fail++; $display("FAIL reset_error got=%0b want=0", error); end
  endtask

  task automatic test_single_record(input bit gappy, input string tag);
    int le;
    int fe;
    do_reset();
    send_record(32'h0005_0001, 32'hDEAD_BEEF, gappy, 1'b0);
    le = last_edge;
    fe = first_edge;
    n_tests++; if (config_write !== 1'b1) begin n_fail++; $display("FAIL %s_write_next got=%0b want=1", tag, config_write); end
    n_tests++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL %s_ready_issue got=%0b want=0", tag, in_ready); end
    n_tests++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL %s_busy_issue got=%0b want=1", tag, busy); end
    wait_cycles(HOLD + 3);
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL %s_nwrites got=%0d want=1", tag, obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_tests++; if (obs_q[0].addr !== 32'h0005_0001) begin n_fail++; $display("FAIL %s_addr got=%h want=00050001", tag, obs_q[0].addr); end
      n_tests++; if (obs_q[0].data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL %s_data got=%h want=deadbeef", tag, obs_q[0].data); end
      n_tests++; if (obs_q[0].len !== HOLD)  begin n_fail++; $display("FAIL %s_hold got=%0d want=%0d", tag, obs_q[0].len, HOLD); end
      n_tests++; if (obs_q[0].start !== le)  begin n_fail++; $display("FAIL %s_start got=%0d want=%0d", tag, obs_q[0].start, le); end
    end
    n_tests++; if (words_loaded !== 16'd1) begin n_fail++; $display("FAIL %s_words got=%0d want=1", tag, words_loaded); end
    n_tests++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL %s_busy_after got=%0b want=0", tag, busy); end
    if (gappy) begin
      n_tests++; if (le - fe !== 2 * (REC_N - 1)) begin n_fail++; $display("FAIL %s_span got=%0d want=%0d", tag, le - fe, 2 * (REC_N - 1)); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e0;
    exp_t e1;
    int   le1;
    do_reset();
    e0.addr = rand_addr(); e0.data = 32'($urandom);
    e1.addr = rand_addr(); e1.data = 32'($urandom);
    send_record(e0.addr, e0.data, 1'b0, 1'b0);
    le1 = last_edge;
    send_record(e1.addr, e1.data, 1'b0, 1'b0);
    n_tests++; if (first_edge - le1 !== HOLD + 1) begin n_fail++; $display("FAIL b2b_stall got=%0d want=%0d", first_edge - le1, HOLD + 1); end
    wait_cycles(HOLD + 3);
    n_tests++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL b2b_nwrites got=%0d want=2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_tests++; if (obs_q[0].addr !== e0.addr || obs_q[0].data !== e0.data) begin n_fail++; $display("FAIL b2b_rec0 got=%h/%h want=%h/%h", obs_q[0].addr, obs_q[0].data, e0.addr, e0.data); end
      n_tests++; if (obs_q[1].addr !== e1.addr || obs_q[1].data !== e1.data) begin n_fail++; $display("FAIL b2b_rec1 got=%h/%h want=%h/%h", obs_q[1].addr, obs_q[1].data, e1.addr, e1.data); end
      n_tests++; if (obs_q[1].start - (obs_q[0].start + obs_q[0].len) < 1) begin n_fail++; $display("FAIL b2b_gap got=%0d want>=1", obs_q[1].start - (obs_q[0].start + obs_q[0].len)); end
    end
    n_tests++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL b2b_words got=%0d want=2", words_loaded); end
  endtask

  // Runs after test_back_to_back so words_loaded starts at 2
  task automatic test_terminator();
    logic [31:0] a;
    logic [31:0] d;
    send_record(IDLE, 32'h0, 1'b0, 1'b0);
    n_tests++; if (done !== 1'b1)         begin n_fail++; $display("FAIL term_done got=%0b want=1", done); end
    n_tests++; if (config_write !== 1'b0) begin n_fail++; $display("FAIL term_write got=%0b want=0", config_write); end
    n_tests++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL term_ready got=%0b want=1", in_ready); end
    wait_cycles(4);
    n_tests++; if (obs_q.size() !== 2)     begin n_fail++; $display("FAIL term_nwrites got=%0d want=2", obs_q.size()); end
    n_tests++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL term_words_hold got=%0d want=2", words_loaded); end
    a = rand_addr();
    d = 32'($urandom);
    send_byte(rec_byte(a, d, 0, 1'b0));
    n_tests++; if (done !== 1'b0)          begin n_fail++; $display("FAIL term_done_clr got=%0b want=0", done); end
    n_tests++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL term_words_clr got=%0d want=0", words_loaded); end
    n_tests++; if (busy !== 1'b1)          begin n_fail++; $display("FAIL term_busy got=%0b want=1", busy); end
    for (int i = 1; i < REC_N; i++) send_byte(rec_byte(a, d, i, 1'b0));
    wait_cycles(HOLD + 3);
    n_tests++; if (obs_q.size() !== 3) begin n_fail++; $display("FAIL term_next_nwrites got=%0d want=3", obs_q.size()); end
    if (obs_q.size() == 3) begin
      n_tests++; if (obs_q[2].addr !== a || obs_q[2].data !== d) begin n_fail++; $display("FAIL term_next_rec got=%h/%h want=%h/%h", obs_q[2].addr, obs_q[2].data, a, d); end
    end
    n_tests++; if (words_loaded !== 16'd1) begin n_fail++; $display("FAIL term_next_words got=%0d want=1", words_loaded); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [31:0] d;
    do_reset();
    a = rand_addr(); d = 32'($urandom);
    for (int i = 0; i < 6; i++) send_byte(rec_byte(a, d, i, 1'b0));
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_pre got=%0b want=1", busy); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
    n_tests++; if (config_addr !== IDLE) begin n_fail++; $display("FAIL rstmid_addr got=%h want=%h", config_addr, IDLE); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    a = rand_addr(); d = 32'($urandom);
    send_record(a, d, 1'b0, 1'b0);
    wait_cycles(HOLD + 3);
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL rstmid_nwrites got=%0d want=1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      n_tests++; if (obs_q[0].addr !== a || obs_q[0].data !== d) begin n_fail++; $display("FAIL rstmid_rec got=%h/%h want=%h/%h", obs_q[0].addr, obs_q[0].data, a, d); end
    end
    // Reset while a record is on the bus
    send_record(rand_addr(), 32'($urandom), 1'b0, 1'b0);
    n_tests++; if (config_write !== 1'b1) begin n_fail++; $display("FAIL rstissue_write_pre got=%0b want=1", config_write); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (config_write !== 1'b0) begin n_fail++; $display("FAIL rstissue_write got=%0b want=0", config_write); end
    n_tests++; if (config_addr !== IDLE || config_data !== 32'h0) begin n_fail++; $display("FAIL rstissue_bus got=%h/%h want=%h/0", config_addr, config_data, IDLE); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstissue_ready got=%0b want=1", in_ready); end
    do_reset();
    n_tests++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL rstissue_words got=%0d want=0", words_loaded); end
  endtask

  task automatic test_random();
    exp_t e;
    int   k;
    do_reset();
    k = 20;
    for (int n = 0; n < k; n++) begin
      e.addr = rand_addr();
      e.data = 32'($urandom);
      exp_q.push_back(e);
      send_record(e.addr, e.data, 1'($urandom_range(0, 1)), 1'b0);
      wait_cycles($urandom_range(0, 3));
    end
    wait_cycles(HOLD + 3);
    n_tests++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_nwrites got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < k && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data || obs_q[i].len !== HOLD) begin
        n_fail++;
        $display("FAIL rand_rec%0d got=%h/%h/%0d want=%h/%h/%0d", i, obs_q[i].addr, obs_q[i].data, obs_q[i].len, exp_q[i].addr, exp_q[i].data, HOLD);
      end
    end
    n_tests++; if (words_loaded !== 16'(k)) begin n_fail++; $display("FAIL rand_words got=%0d want=%0d", words_loaded, k); end
  endtask

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] a;
    logic [31:0] d;
    do_reset();
    send_record(rand_addr(), 32'($urandom), 1'b0, 1'b1);
    wait_cycles(HOLD + 3);
    n_tests++; if (obs_q.size() !== 0)     begin n_fail++; $display("FAIL chk_bad_nwrites got=%0d want=0", obs_q.size()); end
    n_tests++; if (error !== 1'b1)         begin n_fail++; $display("FAIL chk_bad_error got=%0b want=1", error); end
    n_tests++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL chk_bad_words got=%0d want=0", words_loaded); end
    n_tests++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL chk_bad_busy got=%0b want=0", busy); end
    send_record(IDLE, 32'h0, 1'b0, 1'b1);
    wait_cycles(2);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL chk_badterm_done got=%0b want=0", done); end
    a = rand_addr(); d = 32'($urandom);
    send_record(a, d, 1'b0, 1'b0);
    wait_cycles(HOLD + 3);
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL chk_good_nwrites got=%0d want=1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      n_tests++; if (obs_q[0].addr !== a || obs_q[0].data !== d) begin n_fail++; $display("FAIL chk_good_rec got=%h/%h want=%h/%h", obs_q[0].addr, obs_q[0].data, a, d); end
    end
    n_tests++; if (error !== 1'b1)         begin n_fail++; $display("FAIL chk_error_sticky got=%0b want=1", error); end
    n_tests++; if (words_loaded !== 16'd1) begin n_fail++; $display("FAIL chk_good_words got=%0d want=1", words_loaded); end
  endtask
`endif

  task automatic test_bus_hygiene();
    n_tests++; if (idle_err !== 0)     begin n_fail++; $display("FAIL idle_bus got=%0d bad cycles want=0", idle_err); end
    n_tests++; if (unstable_err !== 0) begin n_fail++; $display("FAIL bus_stable got=%0d changes want=0", unstable_err); end
    n_tests++; if (send_timeout !== 1'b0) begin n_fail++; $display("FAIL stream_stall got=%0b want=0", send_timeout); end
  endtask

  initial begin
    test_reset();
    test_single_record(1'b0, "single");
    test_back_to_back();
    test_terminator();
    test_reset_mid();
    test_single_record(1'b1, "gappy");
    test_random();
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_bus_hygiene();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
